dec_gray2bin_seq: RTL
=====================

Name: dec_gray2bin_seq

Overview:
Sequential Gray-to-binary decoder. It is the receive-side counterpart of the team's combinational enc_bin2gray (10-bit binary-to-Gray).
- Accepts one Gray word over a valid/ready handshake.
- Resolves it MSB-first, one bit per clock, using the XOR-prefix chain.
- Presents the binary result over a second valid/ready handshake.
- Sits in front of consumers of Gray-coded counters and pointers crossing from encoder-side logic.

Parameters:
WIDTH, 10, word width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
in_valid  input  1  gray holds a word to decode.
in_ready  output  1  decoder can accept a word this cycle.
gray  input  WIDTH  Gray-coded input word; sampled only on acceptance.
out_valid  output  1  bin holds a decoded result.
out_ready  input  1  downstream takes bin this cycle.
bin  output  WIDTH  decoded binary word; registered output.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to IDLE; out_valid=0; bin=0; internal Gray capture register=0; bit index=0.
  - in_ready=0 while rst_n is low, and in the cycle after rst_n deasserts it is 1.
  - Reset overrides every other event, including a handshake in the same cycle.
- in_ready is combinational: 1 when state==IDLE, or when state==DONE and out_ready==1. Otherwise 0.
- Acceptance: edge where in_valid & in_ready.
  - Capture gray into greg.
  - Set bin[WIDTH-1]=gray[WIDTH-1]; clear all lower bits of bin.
  - Set idx=WIDTH-2.
  - Next state is DECODE, or DONE directly if WIDTH==1.
- States:
  - IDLE:
    - out_valid=0.
    - On acceptance, go to DECODE (WIDTH>1) or DONE (WIDTH==1).
  - DECODE:
    - Each edge: bin[idx] <= bin[idx+1] ^ greg[idx]; idx <= idx-1.
    - On the edge that writes idx==0, go to DONE.
    - in_ready=0, out_valid=0. in_valid is ignored.
  - DONE:
    - out_valid=1; bin holds its value stable.
    - If out_ready=1 and in_valid=1: accept the new word on that same edge (back-to-back) and go to DECODE, or stay in DONE if WIDTH==1.
    - If out_ready=1 and in_valid=0: go to IDLE.
    - If out_ready=0: hold everything.
- Latency:
  - out_valid rises WIDTH-1 clock edges after the acceptance edge; WIDTH=10 gives 9 edges.
  - WIDTH=1 gives out_valid on the edge right after acceptance.
  - Throughput is one word per WIDTH cycles with continuous out_ready.
- Arithmetic:
  - The result must equal the prefix XOR: bin[i] = XOR of gray[WIDTH-1:i] for every i.
  - decode(enc_bin2gray(x)) == x for every x.
- gray changes while not accepting have no effect.
- out_valid never deasserts without out_ready=1 or reset.
- Reset mid-DECODE or mid-DONE discards the word and forces out_valid=0 and bin=0 on that edge. No partial result is ever flagged valid.
- Bits of bin below the current idx read 0 during DECODE. They are not observable as valid.

Test Plan:
1. Reset, then gray=10'h000, out_ready=1 -> out_valid high 9 edges after acceptance, bin=10'h000, then in_ready=1 in IDLE.
2. gray=10'h200 -> bin=10'h3FF. gray=10'h3FF -> bin=10'h2AA. gray=10'h001 -> bin=10'h001. gray=10'h003 -> bin=10'h002.
3. Round trip: for all x in 0..1023 feed gray = x ^ (x>>1) -> bin==x every time; in_valid held high and out_ready=1 gives exactly one acceptance per 10 cycles with no bubbles beyond DECODE.
4. Backpressure: after out_valid with bin=10'h2AA, hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid=1, bin stable at 10'h2AA, in_ready=0 throughout; raise out_ready -> same-edge acceptance of the next word.
5. Reset mid-decode: assert rst_n=0 for one edge 4 cycles after accepting 10'h3FF -> out_valid=0, bin=0, in_ready=1 the cycle after release; a new word 10'h200 decodes to 10'h3FF with full 9-edge latency.
6. WIDTH=1 instance: gray=1'b1 -> out_valid on the edge after acceptance with bin=1'b1; back-to-back words with out_ready=1 -> one result per cycle.

Source files
------------

// File: rtl/dec_gray2bin_seq.sv
// -----------------------------------------------------------------------------
// dec_gray2bin_seq
//
// Sequential Gray-to-binary decoder. This is the receive-side partner of the
// combinational binary-to-Gray encoder. It takes one Gray word through a
// valid/ready handshake. It then resolves the binary value MSB-first, one bit
// per clock, along the XOR-prefix chain:
//     bin[W-1] = gray[W-1]
//     bin[i]   = bin[i+1] ^ gray[i]
// The finished word is presented through a second valid/ready handshake.
//
// Parameters
//   WIDTH      word width in bits, 1..32 (default 10)
//
// Ports
//   clk        rising-edge clock, the only clock of the block
//   rst_n      synchronous active-low reset, sampled on the rising edge of clk
//   in_valid   gray carries a word to decode
//   in_ready   decoder accepts a word this cycle (combinational)
//   gray       Gray-coded input word, sampled only on acceptance
//   out_valid  bin carries a completed result (registered)
//   out_ready  downstream takes bin this cycle
//   bin        decoded binary word (registered)
//
// Timing
//   The acceptance edge loads the MSB. Each following edge resolves one more
//   bit, so out_valid rises WIDTH-1 edges after acceptance. A result held in
//   DONE can be retired on the same edge that accepts the next word, which
//   gives one word per WIDTH cycles when out_ready stays high.
// -----------------------------------------------------------------------------
module dec_gray2bin_seq #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin
);

    // The bit index only has to reach WIDTH-2. A WIDTH of 1 never decodes
    // serially, but it still needs a legal 1-bit index vector.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // First bit resolved after acceptance. The MSB is written directly on the
    // acceptance edge.
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'((WIDTH > 1) ? (WIDTH - 2) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] greg_reg;       // Gray word captured at acceptance
    logic [WIDTH-1:0] bin_reg;        // partially or fully resolved binary word
    logic [IDX_W-1:0] idx_reg;        // next bit position to resolve
    logic             out_valid_reg;

    logic [WIDTH-1:0] step_bin;       // bin_reg with bit idx_reg resolved
    logic             accept;

    // -------------------------------------------------------------------------
    // Input handshake
    // -------------------------------------------------------------------------
    // A new word is taken when the decoder is empty. It is also taken when the
    // finished result is being retired on this same edge. Gating with rst_n
    // keeps the upstream producer from believing that a word was taken on an
    // edge where reset discards it.
    assign in_ready = rst_n & ((state_reg == IDLE) |
                               ((state_reg == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    // -------------------------------------------------------------------------
    // One decode step
    // -------------------------------------------------------------------------
    // Each bit position has its own small mux. The mux replaces the bit when
    // idx_reg points at that position. This builds a one-hot bit update
    // without a variable-index write inside the sequential block. The bit
    // above the current index is already final, so the step is a single XOR.
    //
    // The MSB always equals the captured Gray MSB. Driving it from greg_reg
    // keeps the capture register fully used, and it gives the same value as
    // bin_reg after every load or reset.
    assign step_bin[WIDTH-1] = greg_reg[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi = gi + 1) begin : g_step
            localparam logic [IDX_W-1:0] BIT_IDX = IDX_W'(gi);

            assign step_bin[gi] = (idx_reg == BIT_IDX)
                                ? (bin_reg[gi+1] ^ greg_reg[gi])
                                : bin_reg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM and datapath registers
    // -------------------------------------------------------------------------
    // The accept branch covers both IDLE and the back-to-back case in DONE.
    // The state-specific branches therefore only handle the non-accepting
    // cycles. Bits below the current index stay 0 while decoding. They fill in
    // top-down and are never flagged valid before the last step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            bin_reg       <= '0;
            greg_reg      <= '0;
            idx_reg       <= '0;
        end else if (accept) begin
            greg_reg           <= gray;
            bin_reg            <= '0;
            bin_reg[WIDTH-1]   <= gray[WIDTH-1];
            idx_reg            <= IDX_START;
            if (WIDTH == 1) begin
                // A single bit is already fully decoded by the load.
                state_reg     <= DONE;
                out_valid_reg <= 1'b1;
            end else begin
                state_reg     <= DECODE;
                out_valid_reg <= 1'b0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    out_valid_reg <= 1'b0;
                end

                DECODE: begin
                    // in_valid is ignored here because in_ready is low.
                    bin_reg <= step_bin;
                    idx_reg <= idx_reg - 1'b1;
                    if (idx_reg == '0) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end

                DONE: begin
                    // Without out_ready everything holds, so the result stays
                    // valid and stable until the consumer takes it.
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign bin       = bin_reg;

endmodule
